// File: rtl/tmr_mon_pkg.sv
// Shared definitions for the TMR vote monitor: replica/counter
// indices and the counter-readout state machine encoding.
package tmr_mon_pkg;

    localparam logic [1:0] REP_A      = 2'd0;
    localparam logic [1:0] REP_B      = 2'd1;
    localparam logic [1:0] REP_C      = 2'd2;
    localparam logic [1:0] SEL_UNCORR = 2'd3;

    localparam int NUM_CNT = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } rd_state_e;

endpackage

// File: rtl/tmr_err_counter.sv
// Saturating event counter with synchronous read-clear; a clear and an
// increment in the same cycle leave the counter at 1.
module tmr_err_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_inc,
    input  logic                 i_clr,
    output logic [CNT_WIDTH-1:0] o_count
);

    localparam logic [CNT_WIDTH-1:0] MAX = '1;

    logic [CNT_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= CNT_WIDTH'(i_inc);
        end else if (i_inc && (r_count != MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/tmr_vote_monitor.sv
// Registered bitwise majority voter for three replicas, with mismatch
// counters, persistent-fault flags and a read-and-clear counter port.
module tmr_vote_monitor
    import tmr_mon_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8,
    parameter int PERSIST   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     inA,
    input  logic [WIDTH-1:0]     inB,
    input  logic [WIDTH-1:0]     inC,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out,
    output logic                 err_pulse,
    output logic                 uncorr_pulse,
    output logic [2:0]           fault_mask,
    input  logic                 clr_fault,
    input  logic                 cnt_rd,
    input  logic [1:0]           cnt_sel,
    output logic                 cnt_valid,
    output logic [CNT_WIDTH-1:0] cnt_data
);

    localparam logic [3:0] RUN_MAX = 4'(PERSIST);

    logic [WIDTH-1:0]     w_maj;
    logic [2:0]           w_mis;
    logic                 w_uncorr;
    logic [3:0]           w_inc;
    logic [3:0]           w_clr;
    logic                 w_rd_go;
    logic [CNT_WIDTH-1:0] w_cnt [NUM_CNT];
    logic [3:0]           w_run_nxt [3];
    rd_state_e            w_state_nxt;

    logic [WIDTH-1:0]     r_out;
    logic                 r_out_valid;
    logic                 r_err;
    logic                 r_unc;
    logic [2:0]           r_mask;
    logic [3:0]           r_run [3];
    rd_state_e            r_state;
    logic [CNT_WIDTH-1:0] r_cnt_data;

    assign w_maj = (inA & inB) | (inB & inC) | (inA & inC);

    assign w_mis[REP_A] = in_valid && (inA != w_maj);
    assign w_mis[REP_B] = in_valid && (inB != w_maj);
    assign w_mis[REP_C] = in_valid && (inC != w_maj);
    assign w_uncorr     = in_valid && (inA != inB) &&
                          (inB != inC) && (inA != inC);

    assign w_inc = {w_uncorr, w_mis};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_unc       <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            r_err       <= |w_mis;
            r_unc       <= w_uncorr;
            if (in_valid) begin
                r_out <= w_maj;
            end
        end
    end

    // A mismatch run saturates at PERSIST; any clean valid word restarts it.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_run_nxt[i] = 4'd0;
            if (w_mis[i]) begin
                w_run_nxt[i] = (r_run[i] == RUN_MAX) ? RUN_MAX
                                                     : r_run[i] + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_fault) begin
            r_mask <= '0;
            for (int i = 0; i < 3; i++) begin
                r_run[i] <= 4'd0;
            end
        end else if (in_valid) begin
            for (int i = 0; i < 3; i++) begin
                r_run[i] <= w_run_nxt[i];
                if (w_run_nxt[i] == RUN_MAX) begin
                    r_mask[i] <= 1'b1;
                end
            end
        end
    end

    assign w_rd_go = (r_state == ST_IDLE) && cnt_rd;

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        assign w_clr[g] = w_rd_go && (cnt_sel == 2'(g));

        tmr_err_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .i_inc   (w_inc[g]),
            .i_clr   (w_clr[g]),
            .o_count (w_cnt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (cnt_rd) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Snapshot is the pre-increment value; the counter itself clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_data <= '0;
        end else if (w_rd_go) begin
            r_cnt_data <= w_cnt[cnt_sel];
        end
    end

    assign out          = r_out;
    assign out_valid    = r_out_valid;
    assign err_pulse    = r_err;
    assign uncorr_pulse = r_unc;
    assign fault_mask   = r_mask;
    assign cnt_valid    = (r_state == ST_RESP);
    assign cnt_data     = r_cnt_data;

endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Bench for tmr_vote_monitor: directed scenarios plus random traffic,
// compared every cycle against a behavioural model.
module tb_tmr_vote_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] inA, inB, inC;
    logic       out_valid;
    logic [7:0] out_w;
    logic       err_pulse, uncorr_pulse;
    logic [2:0] fault_mask;
    logic       clr_fault, cnt_rd;
    logic [1:0] cnt_sel;
    logic       cnt_valid;
    logic [7:0] cnt_data;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    localparam int P = 3;

    tmr_vote_monitor #(.WIDTH(8), .CNT_WIDTH(8), .PERSIST(P)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .inA          (inA),
        .inB          (inB),
        .inC          (inC),
        .out_valid    (out_valid),
        .out          (out_w),
        .err_pulse    (err_pulse),
        .uncorr_pulse (uncorr_pulse),
        .fault_mask   (fault_mask),
        .clr_fault    (clr_fault),
        .cnt_rd       (cnt_rd),
        .cnt_sel      (cnt_sel),
        .cnt_valid    (cnt_valid),
        .cnt_data     (cnt_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model
    logic [7:0] m_out;
    bit         m_ov, m_err, m_unc, m_resp;
    logic [7:0] m_cdata;
    bit [2:0]   m_mask;
    int         m_run [3];
    int         m_cnt [4];

    always @(posedge clk) begin : model
        logic [7:0] r [3];
        logic [7:0] mj;
        bit         mis [3];
        bit         unc;
        int         ones;
        if (rst) begin
            m_out = 0; m_ov = 0; m_err = 0; m_unc = 0;
            m_resp = 0; m_cdata = 0; m_mask = 0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else begin
            r[0] = inA; r[1] = inB; r[2] = inC;
            for (int b = 0; b < 8; b++) begin
                ones = int'(r[0][b]) + int'(r[1][b]) + int'(r[2][b]);
                mj[b] = (ones >= 2);
            end
            for (int i = 0; i < 3; i++) mis[i] = in_valid && (r[i] != mj);
            unc = in_valid && r[0] != r[1] && r[1] != r[2] && r[0] != r[2];
            m_ov = in_valid;
            if (in_valid) m_out = mj;
            m_err = mis[0] || mis[1] || mis[2];
            m_unc = unc;
            if (!m_resp && cnt_rd) begin
                m_cdata = 8'(m_cnt[cnt_sel]);
                m_cnt[cnt_sel] = 0;
                m_resp = 1;
            end else begin
                m_resp = 0;
            end
            for (int i = 0; i < 3; i++)
                if (mis[i] && m_cnt[i] < 255) m_cnt[i]++;
            if (unc && m_cnt[3] < 255) m_cnt[3]++;
            if (clr_fault) begin
                m_mask = 0;
                for (int i = 0; i < 3; i++) m_run[i] = 0;
            end else if (in_valid) begin
                for (int i = 0; i < 3; i++) begin
                    m_run[i] = mis[i] ? ((m_run[i] + 1 > P) ? P : m_run[i] + 1) : 0;
                    if (m_run[i] == P) m_mask[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_ov);
            check("out", out_w, m_out);
            check("err_pulse", err_pulse, m_err);
            check("uncorr_pulse", uncorr_pulse, m_unc);
            check("fault_mask", fault_mask, m_mask);
            check("cnt_valid", cnt_valid, m_resp);
            check("cnt_data", cnt_data, m_cdata);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_rep(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic v);
        inA = a; inB = b; inC = c; in_valid = v;
    endtask

    task automatic do_read(input logic [1:0] sel, output logic [7:0] val);
        cnt_rd = 1; cnt_sel = sel;
        step();
        cnt_rd = 0;
        check("rd_valid", cnt_valid, 1);
        val = cnt_data;
        step();
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] base;
        rst = 1; clr_fault = 0; cnt_rd = 0; cnt_sel = 0;
        set_rep(0, 0, 0, 0);
        @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        step();
        rst = 0;
        check("rst_out", out_w, 8'h00);
        check("rst_mask", fault_mask, 3'b000);
        check("rst_cv", cnt_valid, 0);

        set_rep(8'h5A, 8'h5A, 8'h5A, 1);
        step();
        in_valid = 0;
        check("clean_out", out_w, 8'h5A);
        check("clean_ov", out_valid, 1);
        check("clean_err", err_pulse, 0);
        for (int s = 0; s < 4; s++) begin
            do_read(2'(s), v);
            check("init_cnt", v, 0);
        end

        set_rep(8'h5B, 8'h5A, 8'h5A, 1);
        step();
        in_valid = 0;
        check("a_err_out", out_w, 8'h5A);
        check("a_err_pulse", err_pulse, 1);
        do_read(REP_A_SEL(), v);
        check("a_cnt_1", v, 1);
        do_read(0, v);
        check("a_cnt_reread", v, 0);

        set_rep(8'h5A, 8'hA5, 8'h5A, 1);
        step();
        check("b_run1", fault_mask, 3'b000);
        step();
        check("b_run2", fault_mask, 3'b000);
        step();
        check("b_run3", fault_mask, 3'b010);
        in_valid = 0;
        clr_fault = 1;
        step();
        clr_fault = 0;
        check("clr_mask", fault_mask, 3'b000);
        set_rep(8'h5A, 8'hA5, 8'h5A, 1);
        step(); step();
        set_rep(8'h5A, 8'h5A, 8'h5A, 1);
        step();
        set_rep(8'h5A, 8'hA5, 8'h5A, 1);
        step(); step();
        in_valid = 0;
        check("broken_run", fault_mask, 3'b000);
        for (int s = 0; s < 3; s++) do_read(2'(s), v);

        set_rep(8'h01, 8'h02, 8'h04, 1);
        step();
        in_valid = 0;
        check("unc_out", out_w, 8'h00);
        check("unc_pulse", uncorr_pulse, 1);
        check("unc_err", err_pulse, 1);
        do_read(3, v);
        check("unc_cnt", v, 1);
        for (int s = 0; s < 3; s++) begin
            do_read(2'(s), v);
            check("rep_cnt_unc", v, 1);
        end

        set_rep(8'h5B, 8'h5A, 8'h5A, 1);
        repeat (300) step();
        in_valid = 0;
        do_read(0, v);
        check("sat_255", v, 255);
        set_rep(8'h5B, 8'h5A, 8'h5A, 1);
        repeat (300) step();
        cnt_rd = 1; cnt_sel = 0;
        step();
        cnt_rd = 0; in_valid = 0;
        check("sat_inc_cv", cnt_valid, 1);
        check("sat_inc_val", cnt_data, 255);
        step();
        do_read(0, v);
        check("after_sat", v, 1);

        cnt_rd = 1; cnt_sel = 1;
        for (int k = 0; k < 4; k++) begin
            step();
            check("held_rd", cnt_valid, (k % 2) == 0);
        end
        cnt_rd = 0;
        step();

        set_rep(8'h5B, 8'h5A, 8'h5A, 1);
        step();
        in_valid = 0;
        cnt_rd = 1; cnt_sel = 0;
        step();
        cnt_rd = 0;
        rst = 1;
        step();
        rst = 0;
        check("rst_resp_cv", cnt_valid, 0);
        check("rst_resp_cd", cnt_data, 0);
        for (int s = 0; s < 4; s++) begin
            do_read(2'(s), v);
            check("post_rst_cnt", v, 0);
        end

        for (int n = 0; n < 3000; n++) begin
            base = 8'($urandom);
            inA = base; inB = base; inC = base;
            if ($urandom_range(0, 4) == 0) inA = base ^ 8'($urandom);
            if ($urandom_range(0, 2) == 0) inB = base ^ 8'($urandom_range(1, 255));
            if ($urandom_range(0, 5) == 0) inC = base ^ 8'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            cnt_rd    = ($urandom_range(0, 4) == 0);
            cnt_sel   = 2'($urandom_range(0, 3));
            clr_fault = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 400) == 0);
            step();
        end
        rst = 0; in_valid = 0; cnt_rd = 0; clr_fault = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic [1:0] REP_A_SEL();
        return 2'd0;
    endfunction

endmodule
